// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request front end.
// Defaults, trigger-mode encodings and filter counter width helper.
package irq_pkg;

  localparam int N_IRQ_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 3;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int FILT_W = cnt_width(FILT_CYCLES_DEF);

endpackage

// File: rtl/irq_line_cond.sv
// Per-line conditioner: synchroniser, optional glitch filter
// (IRQ_GLITCH_FILTER_EN), previous-sample flop and rise strobe.
// Ports: clk, rst (async active-low), raw in; lvl, rise out.
module irq_line_cond
  import irq_pkg::*;
#(
  parameter int SYNC = SYNC_STAGES_DEF,
  parameter int FILT = FILT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  logic [SYNC-1:0] sync;
  logic            s;
  logic            f;
  logic            p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC-2:0], raw};
    end
  end

  assign s = sync[SYNC-1];

`ifdef IRQ_GLITCH_FILTER_EN
  localparam int CW = cnt_width(FILT);

  logic [CW-1:0] cnt;

  // f only follows s once s has disagreed for FILT+1 samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      f   <= 1'b0;
    end else if (s == f) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT)) begin
      cnt <= '0;
      f   <= ~f;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign f = s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= 1'b0;
    end else begin
      p <= f;
    end
  end

  assign lvl  = f;
  assign rise = f & ~p;

endmodule

// File: rtl/irq_front.sv
// Interrupt request front end: level/edge detection, pending,
// overflow and masked registered request vector. Optional glitch
// filter selected by IRQ_GLITCH_FILTER_EN.
// Ports: clk, rst (async active-low), irq_raw, trig_mode, mask,
// ack, ovf_clr in; irq_req, irq_any, ovf out.
module irq_front
  import irq_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_raw,
  input  logic [N_IRQ-1:0] trig_mode,
  input  logic [N_IRQ-1:0] mask,
  input  logic [N_IRQ-1:0] ack,
  input  logic             ovf_clr,
  output logic [N_IRQ-1:0] irq_req,
  output logic             irq_any,
  output logic [N_IRQ-1:0] ovf
);

  logic [N_IRQ-1:0] lvl;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] pend_n;
  logic [N_IRQ-1:0] ovf_set;
  logic [N_IRQ-1:0] ovf_n;
  logic [N_IRQ-1:0] req_n;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_line_cond #(
      .SYNC (SYNC_STAGES),
      .FILT (FILT_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .raw  (irq_raw[g]),
      .lvl  (lvl[g]),
      .rise (rise[g])
    );
  end

  // A new edge beats a same-cycle ack so no event is lost.
  always_comb begin
    pend_n  = pend;
    ovf_set = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (trig_mode[i] == TRIG_LEVEL) begin
        pend_n[i] = lvl[i];
      end else begin
        if (rise[i]) begin
          pend_n[i] = 1'b1;
        end else if (ack[i]) begin
          pend_n[i] = 1'b0;
        end
        ovf_set[i] = rise[i] & pend[i] & ~ack[i];
      end
    end
  end

  assign ovf_n = ovf_set | (ovf & ~{N_IRQ{ovf_clr}});
  assign req_n = pend & ~mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= '0;
      ovf     <= '0;
      irq_req <= '0;
      irq_any <= 1'b0;
    end else begin
      pend    <= pend_n;
      ovf     <= ovf_n;
      irq_req <= req_n;
      irq_any <= |req_n;
    end
  end

endmodule

// File: tb/tb_irq_front.sv
// Scoreboard bench for irq_front: directed stimulus pushes
// edge-stamped expectations, a monitor compares at each edge.
module tb_irq_front;
  import irq_pkg::*;

`ifdef IRQ_GLITCH_FILTER_EN
  localparam int D = SYNC_STAGES_DEF + FILT_CYCLES_DEF + 1;
`else
  localparam int D = SYNC_STAGES_DEF;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] req;
    logic [3:0] ov;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] irq_raw;
  logic [3:0] trig_mode;
  logic [3:0] mask;
  logic [3:0] ack;
  logic       ovf_clr;
  logic [3:0] irq_req;
  logic       irq_any;
  logic [3:0] ovf;

  exp_t sb[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  int   k;
  int   j;
  int   m;

  irq_front dut (
    .clk       (clk),
    .rst       (rst),
    .irq_raw   (irq_raw),
    .trig_mode (trig_mode),
    .mask      (mask),
    .ack       (ack),
    .ovf_clr   (ovf_clr),
    .irq_req   (irq_req),
    .irq_any   (irq_any),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name,
                              input logic [3:0] req,
                              input logic [3:0] ov);
    checks++;
    if (irq_req !== req || irq_any !== (|req) || ovf !== ov) begin
      errors++;
      $display("FAIL %s: got req=%b any=%b ovf=%b, want req=%b any=%b ovf=%b",
               name, irq_req, irq_any, ovf, req, |req, ov);
    end
  endfunction

  task automatic expect_at(input int cyc, input logic [3:0] req,
                           input logic [3:0] ov, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.req  = req;
    e.ov   = ov;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every edge is an output beat; pop what is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
        e = sb.pop_front();
        if (e.cyc < edge_n) begin
          checks++;
          errors++;
          $display("FAIL %s: missed edge %0d, now %0d", e.name, e.cyc, edge_n);
        end else begin
          chk(e.name, e.req, e.ov);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    irq_raw   = '0;
    trig_mode = '0;
    mask      = '0;
    ack       = '0;
    ovf_clr   = 1'b0;
    #1 rst = 1'b0;
    #1 chk("reset_init", 4'b0000, 4'b0000);

    // level mode, all lines high
    tick(2);
    rst     = 1'b1;
    irq_raw = 4'b1111;
    k = edge_n + 1;
    expect_at(k + D, 4'b0000, 4'b0000, "lvl_pre");
    expect_at(k + D + 1, 4'b1111, 4'b0000, "lvl_on");
    tick(D + 3);

    // async reset mid-cycle
    #2 rst = 1'b0;
    #1 chk("reset_async", 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    k = edge_n + 1;
    expect_at(k + D, 4'b0000, 4'b0000, "rel_pre");
    expect_at(k + D + 1, 4'b1111, 4'b0000, "rel_on");
    tick(D + 3);
    irq_raw = 4'b0000;
    k = edge_n + 1;
    expect_at(k + D + 1, 4'b0000, 4'b0000, "lvl_off");
    tick(D + 3);

    // edge latch and ack on line 2
    trig_mode = 4'b0100;
    irq_raw   = 4'b0100;
    k = edge_n + 1;
    expect_at(k + D, 4'b0000, 4'b0000, "edge_pre");
    expect_at(k + D + 1, 4'b0100, 4'b0000, "edge_set");
    expect_at(k + D + 6, 4'b0100, 4'b0000, "edge_hold");
    tick(2);
    irq_raw = 4'b0000;
    tick(D + 5);
    ack = 4'b0100;
    j = edge_n + 1;
    expect_at(j, 4'b0100, 4'b0000, "ack_pre");
    expect_at(j + 1, 4'b0000, 4'b0000, "ack_clr");
    tick(1);
    ack = 4'b0000;
    tick(3);

    // simultaneous events on edge line 0
    trig_mode = 4'b0001;
    irq_raw   = 4'b0001;
    tick(2);
    irq_raw = 4'b0000;
    tick(D + 2);
    expect_at(edge_n + 1, 4'b0001, 4'b0000, "first_pend");
    irq_raw = 4'b0001;
    tick(2);
    irq_raw = 4'b0000;
    tick(D - 2);
    ack = 4'b0001;
    tick(1);
    ack = 4'b0000;
    expect_at(edge_n + 1, 4'b0001, 4'b0000, "rise_ack_keep");
    tick(3);
    irq_raw = 4'b0001;
    tick(2);
    irq_raw = 4'b0000;
    tick(D - 2);
    ovf_clr = 1'b1;
    expect_at(edge_n + 1, 4'b0001, 4'b0001, "ovf_set_wins");
    tick(1);
    ovf_clr = 1'b0;
    tick(3);
    expect_at(edge_n + 1, 4'b0001, 4'b0001, "ovf_sticky");
    tick(1);
    ovf_clr = 1'b1;
    j = edge_n + 1;
    expect_at(j, 4'b0001, 4'b0000, "ovf_clr");
    tick(1);
    ovf_clr = 1'b0;
    ack = 4'b0001;
    j = edge_n + 1;
    expect_at(j + 1, 4'b0000, 4'b0000, "ack0_clr");
    tick(1);
    ack = 4'b0000;
    tick(3);

    // masking of level line 3
    trig_mode = 4'b0000;
    mask      = 4'b1000;
    irq_raw   = 4'b1000;
    k = edge_n + 1;
    expect_at(k + D + 1, 4'b0000, 4'b0000, "mask_hide");
    expect_at(k + D + 3, 4'b0000, 4'b0000, "mask_hide2");
    tick(D + 4);
    mask = 4'b0000;
    m = edge_n + 1;
    expect_at(m, 4'b1000, 4'b0000, "unmask");
    tick(2);
    irq_raw = 4'b0000;
    k = edge_n + 1;
    expect_at(k + D + 1, 4'b0000, 4'b0000, "mask_line_low");
    tick(D + 3);

    // level follow on line 1, ack ignored
    irq_raw = 4'b0010;
    k = edge_n + 1;
    expect_at(k + D, 4'b0000, 4'b0000, "follow_pre");
    for (int i = 1; i <= 5; i++) begin
      expect_at(k + D + i, 4'b0010, 4'b0000, $sformatf("follow_%0d", i));
    end
    expect_at(k + D + 6, 4'b0000, 4'b0000, "follow_end");
    tick(2);
    ack = 4'b0010;
    tick(1);
    ack = 4'b0000;
    tick(2);
    irq_raw = 4'b0000;
    tick(D + 6);

`ifdef IRQ_GLITCH_FILTER_EN
    // glitch rejected, longer pulse passes
    trig_mode = 4'b0001;
    irq_raw   = 4'b0001;
    k = edge_n + 1;
    expect_at(k + D + 1, 4'b0000, 4'b0000, "glitch_a");
    expect_at(k + D + 3, 4'b0000, 4'b0000, "glitch_b");
    tick(2);
    irq_raw = 4'b0000;
    tick(D + 5);
    irq_raw = 4'b0001;
    k = edge_n + 1;
    expect_at(k + D, 4'b0000, 4'b0000, "filt_pre");
    expect_at(k + D + 1, 4'b0001, 4'b0000, "filt_pass");
    tick(4);
    irq_raw = 4'b0000;
    tick(D);
    ack = 4'b0001;
    j = edge_n + 1;
    expect_at(j + 1, 4'b0000, 4'b0000, "filt_ack");
    tick(1);
    ack = 4'b0000;
    tick(3);
`endif

    for (int t = 0; t < 200 && sb.size() > 0; t++) begin
      @(negedge clk);
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
